// File: rtl/aes_pkg.sv
// Shared AES datapath types: byte type, ShiftRows mode encoding and the row offset table.
package aes_pkg;

    localparam int NB_MAX = 8;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        SR_FWD = 1'b0,
        SR_INV = 1'b1
    } sr_mode_e;

    // Cyclic shift C_r applied to row 'row' of an NB-column state.
    // Only the 256-bit block (NB=8) uses the wider offsets for rows 2 and 3.
    function automatic int sr_offset(input int nb, input int row);
        int off_v;
        case (row)
            32'sd0:  off_v = 32'sd0;
            32'sd1:  off_v = 32'sd1;
            32'sd2:  off_v = (nb == 32'sd8) ? 32'sd3 : 32'sd2;
            32'sd3:  off_v = (nb == 32'sd8) ? 32'sd4 : 32'sd3;
            default: off_v = 32'sd0;
        endcase
        return off_v;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows column selector.
// Produces output column 'col' of the permuted state directly from the stored state,
// so the stream can emit one permuted column per cycle without a second buffer.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  byte_t                   state [NB][4],
    input  sr_mode_e                mode,
    input  logic [$clog2(NB)-1:0]   col,
    output logic [31:0]             col_data
);

    localparam int CW = $clog2(NB);

    logic [4:0]    sum_s [4];
    logic [CW-1:0] src_s [4];

    // Per row, pick the source column (col +/- C_r) mod NB; the +NB keeps the inverse non-negative
    always_comb begin
        col_data = 32'h0000_0000;
        sum_s    = '{default: 5'd0};
        src_s    = '{default: '0};
        for (int r = 0; r < 4; r++) begin
            if (mode == SR_FWD) begin
                sum_s[r] = 5'(col) + 5'(sr_offset(NB, r));
            end else begin
                sum_s[r] = 5'(col) + 5'(NB) - 5'(sr_offset(NB, r));
            end
            src_s[r] = CW'(sum_s[r] % 5'(NB));
            col_data[31-8*r -: 8] = state[src_s[r]][r];
        end
    end

endmodule

// File: rtl/shift_rows_stream.sv
// Column-serial ShiftRows / InvShiftRows stage with ping-pong state banks.
// One bank fills from the input stream while the other drains through the permutation,
// giving one column per cycle in both directions without bubbles.
module shift_rows_stream
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_mode,
    output logic        out_last
);

    localparam int            CW       = $clog2(NB);
    localparam logic [CW-1:0] COL_LAST = CW'(NB - 1);

    if (!((NB == 4) || (NB == 6) || (NB == 8))) begin : g_nb_check
        $error("shift_rows_stream: NB must be 4, 6 or 8");
    end

    byte_t         bank_r [2][NB][4];
    sr_mode_e      mode_r [2];
    logic [1:0]    full_r;
    logic          wr_bank_r;
    logic          rd_bank_r;
    logic [CW-1:0] wr_col_r;
    logic [CW-1:0] rd_col_r;

    logic          accept_s;
    logic          take_s;
    logic          wr_last_s;
    logic          rd_last_s;
    byte_t         rd_state_s [NB][4];
    sr_mode_e      rd_mode_s;
    logic [31:0]   perm_col_s;

    // Handshake qualifiers come from registered bank state only, so out_ready never reaches in_ready
    always_comb begin
        in_ready  = ~rst & ~full_r[wr_bank_r];
        out_valid = ~rst & full_r[rd_bank_r];
        accept_s  = in_valid & in_ready;
        take_s    = out_valid & out_ready;
        wr_last_s = (wr_col_r == COL_LAST);
        rd_last_s = (rd_col_r == COL_LAST);
    end

    // Capture accepted columns into the filling bank; the mode is latched on beat 0 only
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int r = 0; r < 4; r++) begin
                bank_r[wr_bank_r][wr_col_r][r] <= in_data[31-8*r -: 8];
            end
            if (wr_col_r == '0) begin
                mode_r[wr_bank_r] <= sr_mode_e'(in_mode);
            end
        end
    end

    // Bank pointers, column counters and full flags; a bank is set by the writer and cleared by the reader
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r    <= 2'b00;
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
            wr_col_r  <= '0;
            rd_col_r  <= '0;
        end else begin
            if (accept_s) begin
                if (wr_last_s) begin
                    wr_col_r  <= '0;
                    wr_bank_r <= ~wr_bank_r;
                end else begin
                    wr_col_r  <= wr_col_r + CW'(1);
                end
            end
            if (take_s) begin
                if (rd_last_s) begin
                    rd_col_r  <= '0;
                    rd_bank_r <= ~rd_bank_r;
                end else begin
                    rd_col_r  <= rd_col_r + CW'(1);
                end
            end
            for (int b = 0; b < 2; b++) begin
                if (accept_s && wr_last_s && (wr_bank_r == 1'(b))) begin
                    full_r[b] <= 1'b1;
                end else if (take_s && rd_last_s && (rd_bank_r == 1'(b))) begin
                    full_r[b] <= 1'b0;
                end
            end
        end
    end

    // Present the draining bank and its mode to the permutation network
    always_comb begin
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd_state_s[c][r] = bank_r[rd_bank_r][c][r];
            end
        end
        rd_mode_s = mode_r[rd_bank_r];
    end

    shift_rows_perm #(
        .NB (NB)
    ) u_perm (
        .state    (rd_state_s),
        .mode     (rd_mode_s),
        .col      (rd_col_r),
        .col_data (perm_col_s)
    );

    // Output beat is zeroed whenever no valid column is presented
    always_comb begin
        if (out_valid) begin
            out_data = perm_col_s;
            out_mode = rd_mode_s;
            out_last = rd_last_s;
        end else begin
            out_data = 32'h0000_0000;
            out_mode = 1'b0;
            out_last = 1'b0;
        end
    end

endmodule
